// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of one single-port memory
// MEM_ARB_RR_EN: round-robin on contention; undefined gives fixed load/store priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_wr_en_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              mem_req_o,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] IF_BUSY = 2'd1;
   localparam logic [1:0] LS_BUSY = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic              idle, ls_wins, if_gnt, ls_gnt;

   assign idle = (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
   // last_owner_q: 0 = fetch, 1 = load/store; the other side wins the next contention
   logic last_owner_q, last_owner_d;
   assign ls_wins      = ls_req_i & (~if_req_i | ~last_owner_q);
   assign last_owner_d = ls_gnt ? 1'b1 : (if_gnt ? 1'b0 : last_owner_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_owner_q <= 1'b0;
      else       last_owner_q <= last_owner_d;
   end
`else
   assign ls_wins = ls_req_i;
`endif

   assign ls_gnt = ~rst_i & idle & ls_wins;
   assign if_gnt = ~rst_i & idle & if_req_i & ~ls_wins;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_en_d     = wr_en_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ls_gnt) begin
               state_d = LS_BUSY;
               addr_d  = ls_addr_i;
               wr_en_d = ls_wr_en_i;
               wdata_d = ls_wdata_i;
            end else if (if_gnt) begin
               state_d = IF_BUSY;
               addr_d  = if_addr_i;
               wr_en_d = 1'b0;
               wdata_d = ls_wdata_i;
            end
         end
         IF_BUSY: begin
            if (mem_ready_i) begin
               if_rdata_d  = mem_rdata_i;
               if_rvalid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         LS_BUSY: begin
            if (mem_ready_i) begin
               if (!wr_en_q) ls_rdata_d = mem_rdata_i;
               ls_rvalid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
      end
   end

   assign if_gnt_o    = if_gnt;
   assign ls_gnt_o    = ls_gnt;
   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign mem_req_o   = ~idle;
   assign mem_wr_en_o = ~idle & wr_en_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   // Reset masks the pending-request terms so stall drops the moment rst_i rises
   assign stall_o     = ~rst_i & (~idle | (if_req_i & ~if_gnt) | (ls_req_i & ~ls_gnt));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Honors MEM_ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i = 1'b0, ls_wr_en_i = 1'b0;
   logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
   logic        ls_gnt_o, ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        mem_req_o, mem_wr_en_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ready_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        stall_o;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_wr_en_i(ls_wr_en_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
      .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Requesters: queued operations, each held until granted
   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } ls_op_t;
   logic [31:0] if_q[$];
   ls_op_t      ls_q[$];
   bit          if_taken = 0, ls_taken = 0;

   always @(posedge clk_i) begin
      #1;
      if (if_taken && if_q.size() > 0) if_q.delete(0);
      if (ls_taken && ls_q.size() > 0) ls_q.delete(0);
      if_taken = 0;
      ls_taken = 0;
      if (if_q.size() > 0) begin if_req_i = 1; if_addr_i = if_q[0]; end
      else begin if_req_i = 0; if_addr_i = '0; end
      if (ls_q.size() > 0) begin
         ls_req_i = 1; ls_wr_en_i = ls_q[0].wr; ls_addr_i = ls_q[0].addr; ls_wdata_i = ls_q[0].data;
      end else begin
         ls_req_i = 0; ls_wr_en_i = 0; ls_addr_i = '0; ls_wdata_i = '0;
      end
   end

   // Memory: answers after wait_n wait states; unwritten words read as addr*3+1
   logic [31:0] mem [logic [31:0]];
   int          wait_n = 0, wcnt = 0;
   bit          spurious = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : a * 3 + 1;
   endfunction

   always @(posedge clk_i) begin
      #1;
      if (!rst_i && mem_req_o) begin
         if (wcnt >= wait_n) begin
            mem_ready_i = 1;
            mem_rdata_i = mem_rd(mem_addr_o);
            if (mem_wr_en_o) mem[mem_addr_o] = mem_wdata_o;
            wcnt = 0;
         end else begin
            mem_ready_i = 0;
            wcnt++;
         end
      end else begin
         mem_ready_i = spurious;
         mem_rdata_i = spurious ? 32'hBAD0BAD0 : '0;
         wcnt = 0;
      end
   end

   // Transaction model: at most one outstanding access, owner answered one cycle after ready
   bit          m_busy = 0, m_own_ls = 0, m_wr = 0, m_last_ls = 0, m_if_rv = 0, m_ls_rv = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_ls_rd = '0;

   function automatic bit ls_preferred();
`ifdef MEM_ARB_RR_EN
      return !m_last_ls;
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit exp_ls_gnt();
      return !rst_i && !m_busy && ls_req_i && (!if_req_i || ls_preferred());
   endfunction

   function automatic bit exp_if_gnt();
      return !rst_i && !m_busy && if_req_i && !exp_ls_gnt();
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_busy = 0; m_wr = 0; m_last_ls = 0; m_if_rv = 0; m_ls_rv = 0;
         m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ls_rd = '0;
      end else begin
         bit g_if, g_ls;
         g_ls = exp_ls_gnt();
         g_if = exp_if_gnt();
         m_if_rv = 0;
         m_ls_rv = 0;
         if (m_busy) begin
            if (mem_ready_i) begin
               if (m_own_ls) begin
                  m_ls_rv = 1;
                  if (!m_wr) m_ls_rd = mem_rdata_i;
               end else begin
                  m_if_rv = 1;
                  m_if_rd = mem_rdata_i;
               end
               m_busy = 0;
            end
         end else if (g_ls || g_if) begin
            m_busy    = 1;
            m_own_ls  = g_ls;
            m_addr    = g_ls ? ls_addr_i : if_addr_i;
            m_wr      = g_ls & ls_wr_en_i;
            m_wdata   = ls_wdata_i;
            m_last_ls = g_ls;
         end
      end
   end

   // Per-cycle compare plus event counters and grant log for directed checks
   int cnt_req = 0, cnt_wr = 0, cnt_stall = 0, cnt_if_rv = 0, cnt_ls_rv = 0;
   bit gnt_log[$];

   always @(negedge clk_i) begin
      bit e_if, e_ls;
      e_ls = exp_ls_gnt();
      e_if = exp_if_gnt();
      chk("if_gnt", if_gnt_o, e_if);
      chk("ls_gnt", ls_gnt_o, e_ls);
      chk("mem_req", mem_req_o, m_busy);
      chk("mem_wr_en", mem_wr_en_o, m_busy & m_wr);
      chk("stall", stall_o, !rst_i && (m_busy || (if_req_i && !e_if) || (ls_req_i && !e_ls)));
      chk("if_rvalid", if_rvalid_o, m_if_rv);
      chk("ls_rvalid", ls_rvalid_o, m_ls_rv);
      chk("if_rdata", if_rdata_o, m_if_rd);
      chk("ls_rdata", ls_rdata_o, m_ls_rd);
      if (m_busy) begin
         chk("mem_addr", mem_addr_o, m_addr);
         if (m_wr) chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      cnt_req   += int'(mem_req_o);
      cnt_wr    += int'(mem_wr_en_o);
      cnt_stall += int'(stall_o);
      cnt_if_rv += int'(if_rvalid_o);
      cnt_ls_rv += int'(ls_rvalid_o);
      if (ls_gnt_o) gnt_log.push_back(1'b1);
      if (if_gnt_o) gnt_log.push_back(1'b0);
      if_taken = if_gnt_o;
      ls_taken = ls_gnt_o;
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic clear_counts();
      cnt_req = 0; cnt_wr = 0; cnt_stall = 0; cnt_if_rv = 0; cnt_ls_rv = 0;
      gnt_log.delete();
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((if_q.size() != 0 || ls_q.size() != 0 || if_req_i || ls_req_i || mem_req_o) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL %s: timeout waiting for idle", nm);
      end
      step();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      #2;
      rst_i = 1;
      if_q.delete();
      ls_q.delete();
      if_taken = 0;
      ls_taken = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #2;
      rst_i = 0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[32'h100] = 32'h00500093;
      #1 rst_i = 1;
      repeat (3) @(posedge clk_i);
      #2;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);
      chk("rst_ls_rdata", ls_rdata_o, 0);
      @(negedge clk_i);
      #2 rst_i = 0;
      step();

      // Single fetch with zero wait states: grant c0, request c1, data c2
      wait_n = 0;
      if_q.push_back(32'h100);
      step();
      chk("f_gnt_c0", if_gnt_o, 1);
      step();
      chk("f_req_c1", mem_req_o, 1);
      chk("f_addr_c1", mem_addr_o, 32'h100);
      step();
      chk("f_rvalid_c2", if_rvalid_o, 1);
      chk("f_rdata_c2", if_rdata_o, 32'h00500093);
      wait_idle("fetch");

      // Load then store with 3 wait states; ls_rdata keeps the load's value
      ls_q.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h0});
      wait_idle("load40");
      chk("load40_rdata", ls_rdata_o, 32'hC1);
      wait_n = 3;
      clear_counts();
      ls_q.push_back('{wr: 1'b1, addr: 32'h2000, data: 32'hDEADBEEF});
      wait_idle("store");
      chk("st_req_cycles", cnt_req, 4);
      chk("st_wr_cycles", cnt_wr, 4);
      chk("st_stall_cycles", cnt_stall, 4);
      chk("st_rvalid_pulses", cnt_ls_rv, 1);
      chk("st_ls_rdata", ls_rdata_o, 32'hC1);
      wait_n = 1;
      ls_q.push_back('{wr: 1'b0, addr: 32'h2000, data: 32'h0});
      wait_idle("load2000");
      chk("ld_back", ls_rdata_o, 32'hDEADBEEF);

      // Spurious ready in idle
      clear_counts();
      spurious = 1;
      repeat (4) step();
      spurious = 0;
      step();
      chk("sp_if_rv", cnt_if_rv, 0);
      chk("sp_ls_rv", cnt_ls_rv, 0);
      chk("sp_if_rdata", if_rdata_o, 32'h00500093);
      chk("sp_ls_rdata", ls_rdata_o, 32'hDEADBEEF);

      // Fetches across a range of wait states
      for (int i = 0; i < 4; i++) begin
         wait_n = i;
         if_q.push_back(32'h1000 + 32'(4 * i));
         wait_idle("fetch_loop");
         chk("fl_rdata", if_rdata_o, (32'h1000 + 32'(4 * i)) * 3 + 1);
      end

      // Contention from a fresh reset
      do_reset();
      wait_n = 0;
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         if_q.push_back(32'h500 + 32'(4 * i));
         ls_q.push_back('{wr: 1'b0, addr: 32'h600 + 32'(4 * i), data: 32'h0});
      end
      wait_idle("contention");
      chk("ct_count", gnt_log.size(), 8);
      begin
         bit exp_order [8];
`ifdef MEM_ARB_RR_EN
         exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
         exp_order = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
         for (int i = 0; i < 8; i++)
            if (i < gnt_log.size()) chk("ct_order", gnt_log[i], exp_order[i]);
      end
      chk("ct_ls_rdata", ls_rdata_o, 32'h60C * 3 + 1);

      // Reset during a load with wait states
      wait_n = 5;
      clear_counts();
      ls_q.push_back('{wr: 1'b0, addr: 32'h300, data: 32'h0});
      begin
         int n = 0;
         while (!mem_req_o && n < 20) begin step(); n++; end
         chk("mr_reached_busy", mem_req_o, 1);
      end
      @(negedge clk_i);
      #2;
      rst_i = 1;
      ls_q.delete();
      if_q.delete();
      ls_taken = 0;
      if_taken = 0;
      #1;
      chk("mr_mem_req", mem_req_o, 0);
      chk("mr_stall", stall_o, 0);
      chk("mr_ls_gnt", ls_gnt_o, 0);
      chk("mr_if_rdata", if_rdata_o, 0);
      chk("mr_ls_rdata", ls_rdata_o, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_i = 0;
      repeat (6) step();
      chk("mr_no_rvalid", cnt_ls_rv, 0);

      // Recovery after reset
      wait_n = 0;
      if_q.push_back(32'h100);
      wait_idle("recover");
      chk("rc_rdata", if_rdata_o, 32'h00500093);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
